render_cmd_sequencer: RTL
=========================

// Module: render_cmd_sequencer
// PURPOSE
//  Queues draw commands (texture, x, y, background flag) and replays each one as
//  an Avalon-MM write burst into the renderer slave: TEX, then X, then Y, then PLOT.
//  It replaces hand-written per-sprite write FSMs in test tops and HPS bridges.
//  It is a parametrised generalisation of those sequences, and adds:
//  - command queueing;
//  - a background-fill mode;
//  - redundant texture-write suppression;
//  - status outputs.
// PARAMETERS
//  DEPTH         8   command FIFO entries; must be a power of 2 and >= 2
//  TEX_W         7   texture code width
//  COORD_W       9   x/y coordinate width
//  ADDR_W        4   Avalon address width
//  REG_X         1   renderer register address for the x coordinate
//  REG_Y         2   renderer register address for the y coordinate
//  REG_TEX       4   renderer register address for the texture code
//  REG_PLOT      6   renderer register address for the plot strobe
//  SKIP_SAME_TEX 1   1 = omit the TEX write when the code equals the last texture written
// PORTS
//  clk            in   1             system clock
//  rst            in   1             asynchronous reset, active-high
//  cmd_valid      in   1             command present on cmd_*
//  cmd_ready      out  1             FIFO can accept a command (= !full)
//  cmd_tex        in   TEX_W         texture code
//  cmd_x          in   COORD_W       x coordinate (ignored when cmd_bg=1)
//  cmd_y          in   COORD_W       y coordinate (ignored when cmd_bg=1)
//  cmd_bg         in   1             background fill: TEX then PLOT only
//  m_address      out  ADDR_W        Avalon master address
//  m_write        out  1             Avalon master write request
//  m_writedata    out  32            Avalon master write data
//  m_waitrequest  in   1             slave stall
//  busy           out  1             state != IDLE, or FIFO not empty
//  queue_level    out  $clog2(DEPTH)+1  FIFO occupancy, range 0..DEPTH
//  cmds_done      out  16            count of completed PLOT writes; wraps to 0
// BEHAVIOUR
//  Reset (async, immediate):
//  - FIFO emptied; state = IDLE; tex_valid = 0.
//  - m_write = 0, m_address = 0, m_writedata = 0.
//  - cmds_done = 0; busy = 0; cmd_ready = 1.
//  - Reset during a write drops m_write at once. The partial command is discarded.
//  Enqueue:
//  - Push on cmd_valid & cmd_ready.
//  - cmd_ready comes from registered full. A pop in the same cycle does not
//    admit a push while full.
//  - Push and pop in the same cycle leave queue_level unchanged.
//  FSM states: IDLE, LOAD, W_TEX, W_X, W_Y, W_PLOT.
//  - IDLE: if FIFO not empty, pop and go to LOAD.
//  - LOAD: register the command. Next state:
//    - W_TEX, unless SKIP_SAME_TEX & tex_valid & cmd_tex == last_tex;
//    - otherwise W_PLOT if bg, else W_X.
//  - W_TEX -> W_X, or -> W_PLOT if bg. Writing sets last_tex and tex_valid.
//  - W_X -> W_Y -> W_PLOT.
//  - W_PLOT -> IDLE; cmds_done increments.
//  Write handshake:
//  - Each W_* state drives m_write=1 with its address and data.
//  - A write completes on the first edge where m_write=1 and m_waitrequest=0.
//    The FSM advances only on that edge.
//  - Address and data stay stable while waitrequest is high.
//  - Consecutive writes are back-to-back: m_write stays 1 across state changes.
//  - m_write = 0 in IDLE and LOAD.
//  Write data:
//  - tex, x, y are zero-extended to 32 bits.
//  - PLOT data = 0.
//  Latency:
//  - Push at cycle N into an empty, idle block -> first m_write at N+3.
//  - Full command with no stalls: 4 write cycles (2 for bg, or 1 for bg with TEX skipped).
//  - Idle overhead: 2 cycles between the end of one command and the first write
//    of the next.
//  Ordering: strictly FIFO. Boundaries: queue_level spans 0..DEPTH inclusive.
//  cmds_done: wraps 0xFFFF -> 0x0000.
// STRUCTURE
//  render_pkg:
//  - REG_* defaults;
//  - state_t enum;
//  - draw_cmd_t packed struct {tex, x, y, bg}.
//  Sub-module render_cmd_fifo:
//  - synchronous FIFO of draw_cmd_t, DEPTH entries;
//  - registered full/empty;
//  - level output.
//  Top: FSM, Avalon output registers, last_tex tracker, cmds_done counter.
// TESTING
//  1. Push {tex=0x06, x=159, y=119, bg=0}, waitrequest=0:
//     writes (4,0x06), (1,159), (2,119), (6,0) on 4 consecutive cycles; cmds_done=1.
//  2. Same command again: no TEX write; 3 writes (1,159), (2,119), (6,0).
//  3. Push {tex=0x6A, bg=1}: writes (4,0x6A), (6,0) only.
//  4. Hold waitrequest=1 for 5 cycles during W_X:
//     m_address=1 and m_writedata=159 stay stable; W_Y starts the cycle after release.
//  5. Push DEPTH+2 commands with waitrequest=1:
//     cmd_ready=0 at queue_level=DEPTH; the extra pushes are refused; order is preserved.
//  6. Assert rst mid-W_Y:
//     m_write=0 immediately, queue_level=0, busy=0;
//     the next command writes TEX (tex_valid cleared).

Source files
------------

// File: rtl/render_pkg.sv
// Shared types for the render command sequencer:
// register map defaults, FSM states and the queued command bundle.
package render_pkg;

    localparam int TEX_W_DEF   = 7;
    localparam int COORD_W_DEF = 9;

    localparam int REG_X_DEF    = 1;
    localparam int REG_Y_DEF    = 2;
    localparam int REG_TEX_DEF  = 4;
    localparam int REG_PLOT_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        W_TEX,
        W_X,
        W_Y,
        W_PLOT
    } state_t;

    typedef struct packed {
        logic [TEX_W_DEF-1:0]   tex;
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic                   bg;
    } draw_cmd_t;

endpackage

// File: rtl/render_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty
// and an occupancy level spanning 0..DEPTH.
module render_cmd_fifo
    import render_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = draw_cmd_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic          do_push;
    logic          do_pop;

    // full is registered, so a same-cycle pop never frees a slot early
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign dout      = mem[rd_ptr];
    assign level_nxt = level + (AW+1)'(do_push) - (AW+1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/render_cmd_sequencer.sv
// Queues draw commands and replays each as an Avalon-MM
// write burst into the renderer: TEX, X, Y, PLOT.
module render_cmd_sequencer
    import render_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int TEX_W         = TEX_W_DEF,
    parameter int COORD_W       = COORD_W_DEF,
    parameter int ADDR_W        = 4,
    parameter int REG_X         = REG_X_DEF,
    parameter int REG_Y         = REG_Y_DEF,
    parameter int REG_TEX       = REG_TEX_DEF,
    parameter int REG_PLOT      = REG_PLOT_DEF,
    parameter bit SKIP_SAME_TEX = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [TEX_W-1:0]       cmd_tex,
    input  logic [COORD_W-1:0]     cmd_x,
    input  logic [COORD_W-1:0]     cmd_y,
    input  logic                   cmd_bg,
    output logic [ADDR_W-1:0]      m_address,
    output logic                   m_write,
    output logic [31:0]            m_writedata,
    input  logic                   m_waitrequest,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic [15:0]            cmds_done
);

    typedef struct packed {
        logic [TEX_W-1:0]   tex;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               bg;
    } cmd_t;

    state_t             state;
    state_t             nxt;
    cmd_t               cmd_in;
    cmd_t               head;
    cmd_t               cur;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               wr_done;
    logic               skip_tex;
    logic [TEX_W-1:0]   last_tex;
    logic               tex_valid;
    logic               wr_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [31:0]        data_nxt;

    assign cmd_in    = '{tex: cmd_tex, x: cmd_x, y: cmd_y, bg: cmd_bg};
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign wr_done   = m_write && !m_waitrequest;
    assign skip_tex  = SKIP_SAME_TEX && tex_valid && (cur.tex == last_tex);

    render_cmd_fifo #(
        .DEPTH (DEPTH),
        .T     (cmd_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .pop   (pop),
        .din   (cmd_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (queue_level)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:   if (!fifo_empty) nxt = LOAD;
            LOAD: begin
                if (!skip_tex)   nxt = W_TEX;
                else if (cur.bg) nxt = W_PLOT;
                else             nxt = W_X;
            end
            W_TEX:  if (wr_done) nxt = cur.bg ? W_PLOT : W_X;
            W_X:    if (wr_done) nxt = W_Y;
            W_Y:    if (wr_done) nxt = W_PLOT;
            W_PLOT: if (wr_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state, so m_write
    // stays high across back-to-back writes and holds while stalled.
    always_comb begin
        wr_nxt   = 1'b0;
        addr_nxt = '0;
        data_nxt = '0;
        unique case (nxt)
            W_TEX: begin
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_W'(REG_TEX);
                data_nxt = 32'(cur.tex);
            end
            W_X: begin
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_W'(REG_X);
                data_nxt = 32'(cur.x);
            end
            W_Y: begin
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_W'(REG_Y);
                data_nxt = 32'(cur.y);
            end
            W_PLOT: begin
                wr_nxt   = 1'b1;
                addr_nxt = ADDR_W'(REG_PLOT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            m_write     <= 1'b0;
            m_address   <= '0;
            m_writedata <= '0;
            cur         <= '0;
            last_tex    <= '0;
            tex_valid   <= 1'b0;
            cmds_done   <= '0;
        end else begin
            state       <= nxt;
            m_write     <= wr_nxt;
            m_address   <= addr_nxt;
            m_writedata <= data_nxt;
            if (pop) cur <= head;
            if (state == W_TEX && wr_done) begin
                last_tex  <= cur.tex;
                tex_valid <= 1'b1;
            end
            if (state == W_PLOT && wr_done)
                cmds_done <= cmds_done + 16'd1;
        end
    end

endmodule
